// File: rtl/game_pkg.sv
// Shared button/event definitions for the game input path: button bit
// indices, event codes, debounce FSM states and the press priority encoder.
package game_pkg;

    localparam int NUM_BTN    = 5;

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    localparam logic [2:0] EVT_CENTER = 3'd0;
    localparam logic [2:0] EVT_UP     = 3'd1;
    localparam logic [2:0] EVT_DOWN   = 3'd2;
    localparam logic [2:0] EVT_LEFT   = 3'd3;
    localparam logic [2:0] EVT_RIGHT  = 3'd4;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_t;

    // Lowest set index wins, so center beats up beats down and so on.
    function automatic logic [2:0] prio_code(input logic [NUM_BTN-1:0] p);
        prio_code = EVT_CENTER;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (p[i]) prio_code = 3'(i);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, debounce FSM producing a level and a
// one-cycle press pulse. AUTOREPEAT_EN adds a held-button repeat counter.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 834_000,
    parameter int REPEAT_DELAY    = 41_728_000,
    parameter int REPEAT_PERIOD   = 8_345_600
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rpt_pulse;

    assign sync  = sync_q[1];
    assign level = level_q;
    assign press = press_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // The cycle that leaves an idle state already counts as the first stable one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = rpt_pulse;
        case (state_q)
            DB_RELEASED: begin
                if (sync) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HELD: begin
                if (!sync) begin
                    state_d = DB_RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DB_RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_RELEASED;
        endcase
    end

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_q, rpt_lim;
    logic          rpt_first_q;

    assign rpt_lim   = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_pulse = (state_q == DB_HELD) && (rpt_q == rpt_lim);

    // Release-wait freezes the count so a brief bounce does not restart the delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            case (state_q)
                DB_HELD: begin
                    if (rpt_pulse) begin
                        rpt_q       <= '0;
                        rpt_first_q <= 1'b0;
                    end else begin
                        rpt_q <= rpt_q + 1'b1;
                    end
                end
                DB_RELEASE_WAIT: ;
                default: begin
                    rpt_q       <= '0;
                    rpt_first_q <= 1'b1;
                end
            endcase
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_pulse  = 1'b0;
`endif

endmodule

// File: rtl/button_event_encoder.sv
// Five debounced buttons -> prioritised 3-bit press events in a FWFT FIFO
// drained by valid/ready. Optional auto-repeat via `define AUTOREPEAT_EN.
module button_event_encoder
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 834_000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 41_728_000,
    parameter int REPEAT_PERIOD   = 8_345_600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               evt_valid,
    output logic [2:0]         evt_code,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pend_q, pend_clr;
    logic               push_req, push_ok, drop, pop, full;
    logic [2:0]         push_code;
    logic [AW:0]        wptr_q, rptr_q, count;
    logic [2:0]         mem [FIFO_DEPTH];
    logic               ovf_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw),
        .level (btn_level),
        .press (press)
    );

    // Isolate the lowest set bit: that is the highest-priority pending press.
    assign pend_clr  = pend_q & (~pend_q + 1'b1);
    assign push_req  = |pend_q;
    assign push_code = prio_code(pend_q);

    assign count     = wptr_q - rptr_q;
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign evt_valid = (wptr_q != rptr_q);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign evt_code  = evt_valid ? mem[rptr_q[AW-1:0]] : EVT_CENTER;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | press;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // On push-to-full with pop, the written slot is the one being read out this cycle.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= push_code;
    end

endmodule
